// File: rtl/cp0_exception_ctrl.sv
// Coprocessor-0 exception controller for the five-stage MIPS core.
//
// Purpose:
//   Decides whether the instruction in M, or a pending hardware interrupt,
//   causes an exception. When one is taken, it raises a one-cycle
//   flush/redirect request. It also holds the CP0 registers SR (12),
//   Cause (13), EPC (14) and PRId (15), and serves mfc0, mtc0 and eret.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   PC_M       PC of the instruction in M
//   ExcCode_M  exception code of the M instruction (0 = none)
//   BD_M       M instruction sits in a branch delay slot
//   HWInt      external interrupt lines
//   CP0Addr    register select for mfc0/mtc0
//   CP0WD      mtc0 write data
//   CP0WE      mtc0 write enable
//   EXLClr     eret in M
//   CP0RD      mfc0 read data (combinational)
//   EPCOut     current EPC, used as the eret target
//   Req        take exception: flush F..M and redirect to ExcPC
//   ExcPC      exception handler entry address
module cp0_exception_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE   = 32'h4255_4141
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_M,
    input  logic [4:0]  ExcCode_M,
    input  logic        BD_M,
    input  logic [5:0]  HWInt,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0WD,
    input  logic        CP0WE,
    input  logic        EXLClr,
    output logic [31:0] CP0RD,
    output logic [31:0] EPCOut,
    output logic        Req,
    output logic [31:0] ExcPC
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    // EPC
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic        take_exc;

    assign int_req  = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req  = (ExcCode_M != 5'd0) & ~exl_q;
    // Registers are already cleared while reset is high, but ExcCode_M may
    // still be nonzero, so the request is gated explicitly.
    assign take_exc = (int_req | exc_req) & ~reset;

    assign Req    = take_exc;
    assign ExcPC  = HANDLER_ADDR;
    assign EPCOut = epc_q;

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        // IP samples the interrupt lines on every edge, whatever else happens.
        ip_d      = HWInt;

        if (take_exc) begin
            // The flushed M instruction loses its own mtc0/eret side effects.
            exl_d     = 1'b1;
            exccode_d = int_req ? 5'd0 : ExcCode_M;
            bd_d      = BD_M;
            epc_d     = BD_M ? (PC_M - 32'd4) : PC_M;
        end else begin
            if (CP0WE) begin
                case (CP0Addr)
                    ADDR_SR: begin
                        im_d  = CP0WD[15:10];
                        exl_d = CP0WD[1];
                        ie_d  = CP0WD[0];
                    end
                    ADDR_EPC: epc_d = CP0WD;
                    default: ;
                endcase
            end
            // eret takes effect after a same-cycle SR write.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        CP0RD = 32'd0;
        case (CP0Addr)
            ADDR_SR:    CP0RD = {16'd0, im_q, 8'd0, exl_q, ie_q};
            ADDR_CAUSE: CP0RD = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
            ADDR_EPC:   CP0RD = epc_q;
            ADDR_PRID:  CP0RD = PRID_VALUE;
            default:    CP0RD = 32'd0;
        endcase
    end

endmodule

// File: doc/cp0_exception_ctrl.md
Name: cp0_exception_ctrl

Overview:
Coprocessor-0 exception controller for the five-stage MIPS core.
- Collects the exception code that has propagated to M (originating from F address checks, D decode, E overflow, M memory checks) together with external hardware interrupts.
- Decides whether to take an exception and raises a one-cycle pipeline flush/redirect request.
- Holds SR, Cause, EPC and PRId, serving mfc0, mtc0 and eret.

Parameters:
HANDLER_ADDR, 32'h0000_4180, exception entry PC driven on redirect
PRID_VALUE, 32'h4255_4141, read-only PRId content

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
PC_M  input  32  PC of instruction in M
ExcCode_M  input  5  exception code of M instruction; 0 = none
BD_M  input  1  M instruction sits in a branch delay slot
HWInt  input  6  external interrupt lines
CP0Addr  input  5  register select for mfc0/mtc0
CP0WD  input  32  mtc0 write data
CP0WE  input  1  mtc0 write enable (M stage)
EXLClr  input  1  eret in M
CP0RD  output  32  mfc0 read data, combinational
EPCOut  output  32  current EPC, for eret target
Req  output  1  take exception: flush F–M, redirect to ExcPC
ExcPC  output  32  constant HANDLER_ADDR

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC(14): 32 bits.
  - PRId(15): constant.
- Unmapped addresses read 0; writes to them, to Cause or to PRId are ignored.
- Reset (async, immediate): SR=0, Cause=0, EPC=0; Req=0 while reset is high; CP0RD reflects reset register values.
- Request logic, combinational from current registers and inputs:
  - IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - ExcReq = (ExcCode_M != 0) & ~SR.EXL.
  - Req = IntReq | ExcReq.
- Priority: interrupt over synchronous exception.
- On the rising edge with Req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCode_M.
  - Cause.BD <= BD_M.
  - EPC <= BD_M ? PC_M-4 : PC_M (32-bit wrap, low 2 bits kept as-is; an AdEL PC is stored unaligned).
- Cause.IP <= HWInt on every edge, unconditionally.
- mtc0 (CP0WE=1, Req=0): SR <= masked CP0WD; EPC <= CP0WD. mtc0 in the same cycle as Req is dropped; the exception update wins.
- eret (EXLClr=1, Req=0): SR.EXL <= 0 at the edge. Req cannot coincide with eret unless EXL=0; if it does, Req wins and EXL ends at 1.
- mtc0 and eret in one cycle: write applied first, then EXL cleared.
- While EXL=1: all requests masked, ExcCode_M ignored, registers change only by mtc0/eret/IP.
- Timing:
  - Read has zero latency.
  - Req asserts in the same cycle as the qualifying condition.
  - State visible on CP0RD the cycle after the edge.
  - Req deasserts the next cycle because EXL=1.
- Flush of the M instruction: its own mtc0 side effects are suppressed as above.

Test Plan:
- Reset mid-operation: set EXL=1, EPC=0x3010; assert reset async -> SR, Cause and EPC read 0 immediately; Req=0 even with ExcCode_M=4.
- Fetch AdEL: PC_M=0x3002, ExcCode_M=4, BD_M=0 -> Req=1 same cycle; next cycle Cause.ExcCode=4, EPC=0x3002, SR.EXL=1, Req=0.
- Delay-slot overflow: PC_M=0x3008, ExcCode_M=12, BD_M=1 -> EPC=0x3004, Cause=0x8000_0030.
- Interrupt priority and masking:
  - SR=0x0000_0401, HWInt=6'b000001, ExcCode_M=10 -> Req=1, Cause.ExcCode=0, IP[10]=1.
  - Same with IE=0 -> Req=0, IP still tracks.
- Masking under EXL and eret:
  - With EXL=1, ExcCode_M=5 -> Req=0, Cause unchanged.
  - EXLClr=1 -> EXL=0 next cycle; EPCOut unchanged.
- mtc0 collision: CP0WE=1, CP0Addr=14, CP0WD=0x1234, with ExcCode_M=8 -> EPC=PC_M, not 0x1234; repeat with ExcCode_M=0 -> EPC=0x1234.
